// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared branch-type encodings and counter helpers for the BTB
package btb_pkg;

  typedef enum logic [1:0] {
    BT_NONE     = 2'b00,
    BT_UNCOND   = 2'b01,
    BT_COND     = 2'b10,
    BT_INDIRECT = 2'b11
  } btype_e;

  localparam int unsigned CNT_MAX_W = 4;

  // Weakly-taken start value: only the MSB set.
  function automatic logic [CNT_MAX_W-1:0] cnt_weak_taken(input int unsigned w);
    logic [CNT_MAX_W:0] v;
    v = 5'd1 << (w - 1);
    return v[CNT_MAX_W-1:0];
  endfunction

  function automatic logic [CNT_MAX_W-1:0] cnt_max(input int unsigned w);
    logic [CNT_MAX_W:0] v;
    v = (5'd1 << w) - 5'd1;
    return v[CNT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up/down next-value logic for direction counters
module sat_counter
  import btb_pkg::*;
#(
  parameter int CNT_WIDTH = 2
) (
  input  logic [CNT_WIDTH-1:0] i_cnt,
  input  logic                 i_up,
  output logic [CNT_WIDTH-1:0] o_next
);

  localparam logic [CNT_MAX_W-1:0] MAX_FULL = cnt_max(CNT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] MAX_VAL  = MAX_FULL[CNT_WIDTH-1:0];

  always_comb begin
    o_next = i_cnt;
    if (i_up) begin
      if (i_cnt != MAX_VAL) o_next = i_cnt + 1'b1;
    end else begin
      if (i_cnt != '0) o_next = i_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/btb_bimodal.sv
// rtl/btb_bimodal.sv - direct-mapped BTB with bimodal direction counters and statistics
module btb_bimodal
  import btb_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int TAG_WIDTH    = 10,
  parameter int CNT_WIDTH    = 2,
  parameter int FETCH_STRIDE = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if0_allowin,
  input  logic [31:0] fetch_pc,
  output logic [31:0] pred_pc,
  output logic        pred_taken,
  output logic        pred_hit,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_tpc,
  input  logic        upd_taken,
  input  logic [1:0]  upd_btype,
  output logic [31:0] stat_lookup,
  output logic [31:0] stat_dir_fail,
  output logic [31:0] stat_add_fail,
  input  logic        predict_dir_fail,
  input  logic        predict_add_fail
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_MAX_W-1:0] CNT_INIT_FULL = cnt_weak_taken(CNT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_INIT      = CNT_INIT_FULL[CNT_WIDTH-1:0];

  logic                 r_valid  [DEPTH];
  logic [TAG_WIDTH-1:0] r_tag    [DEPTH];
  logic [31:0]          r_target [DEPTH];
  logic [1:0]           r_btype  [DEPTH];
  logic [CNT_WIDTH-1:0] r_cnt    [DEPTH];

  logic [31:0] r_stat_lookup;
  logic [31:0] r_stat_dir_fail;
  logic [31:0] r_stat_add_fail;

  logic [IDX_W-1:0]     w_fidx;
  logic [TAG_WIDTH-1:0] w_ftag;
  logic [IDX_W-1:0]     w_uidx;
  logic [TAG_WIDTH-1:0] w_utag;
  logic                 w_fhit;
  logic                 w_ftaken;
  logic                 w_uhit;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_unused_upd_pc;

  assign w_fidx = fetch_pc[3 +: IDX_W];
  assign w_ftag = fetch_pc[3+IDX_W +: TAG_WIDTH];
  assign w_uidx = upd_pc[3 +: IDX_W];
  assign w_utag = upd_pc[3+IDX_W +: TAG_WIDTH];

  // Low alignment bits and bits above the tag never participate in matching.
  assign w_unused_upd_pc = ^{upd_pc[2:0], upd_pc >> (3 + IDX_W + TAG_WIDTH)};

  assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

  always_comb begin
    w_ftaken = 1'b0;
    if (w_fhit) begin
      case (r_btype[w_fidx])
        BT_UNCOND, BT_INDIRECT: w_ftaken = 1'b1;
        BT_COND:                w_ftaken = r_cnt[w_fidx][CNT_WIDTH-1];
        default:                w_ftaken = 1'b0;
      endcase
    end
  end

  assign pred_hit   = w_fhit;
  assign pred_taken = w_ftaken;
  assign pred_pc    = w_ftaken ? r_target[w_fidx] : fetch_pc + 32'(FETCH_STRIDE);

  sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_sat_counter (
    .i_cnt  (r_cnt[w_uidx]),
    .i_up   (upd_taken),
    .o_next (w_cnt_next)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_btype[i]  <= '0;
        r_cnt[i]    <= '0;
      end
    end else if (upd_valid) begin
      if (w_uhit && (upd_btype == BT_NONE)) begin
        // A non-branch aliasing onto a live entry evicts it.
        r_valid[w_uidx] <= 1'b0;
      end else if (w_uhit) begin
        r_cnt[w_uidx] <= w_cnt_next;
        if (predict_add_fail && upd_taken) begin
          r_target[w_uidx] <= upd_tpc;
          r_btype[w_uidx]  <= upd_btype;
        end
      end else if (upd_taken) begin
        r_valid[w_uidx]  <= 1'b1;
        r_tag[w_uidx]    <= w_utag;
        r_target[w_uidx] <= upd_tpc;
        r_btype[w_uidx]  <= upd_btype;
        r_cnt[w_uidx]    <= CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stat_lookup   <= '0;
      r_stat_dir_fail <= '0;
      r_stat_add_fail <= '0;
    end else begin
      if (if0_allowin)                   r_stat_lookup   <= r_stat_lookup + 32'd1;
      if (upd_valid && predict_dir_fail) r_stat_dir_fail <= r_stat_dir_fail + 32'd1;
      if (upd_valid && predict_add_fail) r_stat_add_fail <= r_stat_add_fail + 32'd1;
    end
  end

  assign stat_lookup   = r_stat_lookup;
  assign stat_dir_fail = r_stat_dir_fail;
  assign stat_add_fail = r_stat_add_fail;

endmodule

// File: doc/btb_bimodal.md
# btb_bimodal

Parametrised direct-mapped branch target buffer with per-entry bimodal direction counters, serving the IF0 fetch stage. Each cycle it looks up `fetch_pc` and returns a predicted next PC and a taken flag. It is trained by the resolved-branch update port from EX0. It replaces the static not-taken predictor with tagged entries, configurable saturating counters, branch-type-aware prediction and built-in statistics counters.

## Interface
- `DEPTH`, 16: number of entries; power of two, 4..256.
- `TAG_WIDTH`, 10: tag bits stored per entry, taken from `pc[3+IDX_W +: TAG_WIDTH]`.
- `CNT_WIDTH`, 2: direction counter width, 1..4.
- `FETCH_STRIDE`, 8: byte increment for the not-taken `pred_pc`.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: asynchronous, active-low reset.
- `if0_allowin` in 1: fetch PC is consumed this cycle; gates the statistics counters only.
- `fetch_pc` in 32: lookup address.
- `pred_pc` out 32: predicted next fetch PC.
- `pred_taken` out 1: predicted taken.
- `pred_hit` out 1: lookup hit a valid entry with matching tag.
- `upd_valid` in 1: resolved-branch update this cycle.
- `upd_pc` in 32: PC of the resolved instruction.
- `upd_tpc` in 32: resolved target.
- `upd_taken` in 1: resolved direction.
- `upd_btype` in 2: 00 not-branch, 01 unconditional direct, 10 PC-relative conditional, 11 indirect.
- `stat_lookup` out 32: count of accepted lookups.
- `stat_dir_fail` out 32: count of direction mispredicts.
- `stat_add_fail` out 32: count of target mispredicts.
- `predict_dir_fail` in 1: direction mispredict flag, qualified by `upd_valid`.
- `predict_add_fail` in 1: target mispredict flag, qualified by `upd_valid`.

## Operation
- Index and tag:
  - IDX_W = log2(DEPTH).
  - index = `pc[3 +: IDX_W]`.
  - tag = `pc[3+IDX_W +: TAG_WIDTH]`.
  - The same fields are used for lookup and update.
- Each entry holds `valid`, `tag`, `target[31:0]`, `btype[1:0]` and `cnt[CNT_WIDTH-1:0]`.
- Lookup is purely combinational from the register array:
  - hit = valid && tag match.
  - On hit with btype 01 or 11: `pred_taken` = 1.
  - On hit with btype 10: `pred_taken` = MSB of `cnt`.
  - When `pred_taken` = 1: `pred_pc` = stored target.
  - On miss, or when not taken: `pred_pc` = `fetch_pc` + `FETCH_STRIDE` (mod 2^32) and `pred_taken` = 0.
- Update on a clock edge with `upd_valid` = 1, in priority order:
  1. `upd_btype` = 00 and the entry hits: clear `valid` (aliasing eviction).
  2. Entry hits and `upd_btype` ≠ 00:
     - `cnt` saturating +1 if `upd_taken`, else −1.
     - If `predict_add_fail` && `upd_taken`: overwrite `target` and `btype`.
  3. Miss and `upd_taken`:
     - Allocate, overwriting any occupant.
     - valid = 1, tag, target = `upd_tpc`, btype = `upd_btype`.
     - cnt = weakly-taken, i.e. 2^(CNT_WIDTH−1).
  4. Miss and not taken: no change.
- Counters saturate at 0 and 2^CNT_WIDTH−1 and never wrap.
- Statistics:
  - `stat_lookup` increments when `if0_allowin` is high.
  - `stat_dir_fail` and `stat_add_fail` increment when `upd_valid` && the respective flag is high.
  - All three are 32-bit and wrap modulo 2^32.

## Timing
- Prediction has zero-cycle latency: `pred_*` follow `fetch_pc` combinationally.
- Updates are visible to lookups from the cycle after the update edge.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents. There is no bypass.
- On reset assertion, asynchronously:
  - All `valid` = 0; tag, target and cnt = 0.
  - All stat counters = 0.
  - Outputs therefore read `pred_hit` = 0, `pred_taken` = 0, `pred_pc` = `fetch_pc` + `FETCH_STRIDE`.
- Reset mid-update: the update is lost and the entry is left invalid.
- `if0_allowin` low does not stall or block updates.

## Structure
- Shared package `btb_pkg`:
  - Btype constants: BT_NONE, BT_UNCOND, BT_COND, BT_INDIRECT.
  - Counter init/saturation helper functions.
- One sub-module, `sat_counter`: a CNT_WIDTH-parameterised saturating up/down next-value function block, instanced once in the update path.
- Storage is flop arrays, not RAM, because lookup is asynchronous.

## Test plan
- **Reset:** hold `rstn` = 0, `fetch_pc` = 0x1C000000 → `pred_hit` = 0, `pred_taken` = 0, `pred_pc` = 0x1C000008, all stats 0.
- **Allocate conditional:** update pc = 0x1C000010, tpc = 0x1C000100, taken, btype 10, `add_fail` = 1. Next cycle, fetch 0x1C000010 → hit, taken, `pred_pc` = 0x1C000100, `stat_add_fail` = 1.
- **Counter hysteresis:** CNT_WIDTH = 2 on that entry.
  - Two not-taken updates → `pred_taken` = 0 and `pred_pc` = 0x1C000018.
  - Three further not-taken updates keep cnt = 0.
  - One taken update → still not taken.
  - A second taken update → taken.
- **Unconditional ignores counter:** btype 01 entry forced to cnt = 0 via not-taken updates → `pred_taken` still 1.
- **Aliasing:**
  - Update pc = 0x1C000010 + (DEPTH×8) (same index, different tag), taken → the old PC now misses.
  - A btype 00 update at the new PC → entry invalid.
- **Same-cycle collision:** lookup and first allocating update to the same index in one cycle → that cycle returns miss, the next cycle returns hit.
